// File: rtl/svc_sram_arb.sv
// Two-client SRAM command/response arbiter: burst-atomic round-robin grant on the
// command path, response routing by the client tag carried in the meta MSB.
module svc_sram_arb #(
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DATA_WIDTH   = 16,
  parameter int SRAM_STRB_WIDTH   = SRAM_DATA_WIDTH / 8,
  parameter int CLIENT_META_WIDTH = 4,
  parameter int SRAM_META_WIDTH   = CLIENT_META_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s0_cmd_valid,
  output logic                         s0_cmd_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0]   s0_cmd_addr,
  input  logic [CLIENT_META_WIDTH-1:0] s0_cmd_meta,
  input  logic                         s0_cmd_last,
  input  logic                         s0_cmd_wr_en,
  input  logic [SRAM_DATA_WIDTH-1:0]   s0_cmd_wr_data,
  input  logic [SRAM_STRB_WIDTH-1:0]   s0_cmd_wr_strb,
  output logic                         s0_rd_resp_valid,
  input  logic                         s0_rd_resp_ready,
  output logic [SRAM_DATA_WIDTH-1:0]   s0_rd_resp_data,
  output logic [CLIENT_META_WIDTH-1:0] s0_rd_resp_meta,
  output logic                         s0_rd_resp_last,
  input  logic                         s1_cmd_valid,
  output logic                         s1_cmd_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0]   s1_cmd_addr,
  input  logic [CLIENT_META_WIDTH-1:0] s1_cmd_meta,
  input  logic                         s1_cmd_last,
  input  logic                         s1_cmd_wr_en,
  input  logic [SRAM_DATA_WIDTH-1:0]   s1_cmd_wr_data,
  input  logic [SRAM_STRB_WIDTH-1:0]   s1_cmd_wr_strb,
  output logic                         s1_rd_resp_valid,
  input  logic                         s1_rd_resp_ready,
  output logic [SRAM_DATA_WIDTH-1:0]   s1_rd_resp_data,
  output logic [CLIENT_META_WIDTH-1:0] s1_rd_resp_meta,
  output logic                         s1_rd_resp_last,
  output logic                         sram_cmd_valid,
  input  logic                         sram_cmd_ready,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_cmd_addr,
  output logic [SRAM_META_WIDTH-1:0]   sram_cmd_meta,
  output logic                         sram_cmd_last,
  output logic                         sram_cmd_wr_en,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_cmd_wr_data,
  output logic [SRAM_STRB_WIDTH-1:0]   sram_cmd_wr_strb,
  input  logic                         sram_rd_resp_valid,
  output logic                         sram_rd_resp_ready,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_rd_resp_data,
  input  logic [SRAM_META_WIDTH-1:0]   sram_rd_resp_meta,
  input  logic                         sram_rd_resp_last
);

  // Client-indexed views so the mux is a plain array select.
  logic [1:0]                        c_valid, c_last, c_wr_en;
  logic [1:0][SRAM_ADDR_WIDTH-1:0]   c_addr;
  logic [1:0][CLIENT_META_WIDTH-1:0] c_meta;
  logic [1:0][SRAM_DATA_WIDTH-1:0]   c_wr_data;
  logic [1:0][SRAM_STRB_WIDTH-1:0]   c_wr_strb;

  assign c_valid   = {s1_cmd_valid,   s0_cmd_valid};
  assign c_last    = {s1_cmd_last,    s0_cmd_last};
  assign c_wr_en   = {s1_cmd_wr_en,   s0_cmd_wr_en};
  assign c_addr    = {s1_cmd_addr,    s0_cmd_addr};
  assign c_meta    = {s1_cmd_meta,    s0_cmd_meta};
  assign c_wr_data = {s1_cmd_wr_data, s0_cmd_wr_data};
  assign c_wr_strb = {s1_cmd_wr_strb, s0_cmd_wr_strb};

  logic lock_q, lock_d, lock_id_q, lock_id_d;
  logic hold_q, hold_d, hold_id_q, hold_id_d;
  logic prio_q, prio_d;
  logic sel_act, sel_id, cmd_en, accept;

  // Lock (mid-burst) outranks hold (stalled beat), which outranks round-robin.
  always_comb begin
    sel_act = 1'b0;
    sel_id  = prio_q;
    if (lock_q) begin
      sel_act = 1'b1;
      sel_id  = lock_id_q;
    end else if (hold_q) begin
      sel_act = 1'b1;
      sel_id  = hold_id_q;
    end else if (c_valid[prio_q]) begin
      sel_act = 1'b1;
      sel_id  = prio_q;
    end else if (c_valid[~prio_q]) begin
      sel_act = 1'b1;
      sel_id  = ~prio_q;
    end
  end

  assign cmd_en           = rst_n && sel_act;
  assign sram_cmd_valid   = cmd_en && c_valid[sel_id];
  assign sram_cmd_addr    = c_addr[sel_id];
  assign sram_cmd_meta    = {sel_id, c_meta[sel_id]};
  assign sram_cmd_last    = c_last[sel_id];
  assign sram_cmd_wr_en   = c_wr_en[sel_id];
  assign sram_cmd_wr_data = c_wr_data[sel_id];
  assign sram_cmd_wr_strb = c_wr_strb[sel_id];
  assign s0_cmd_ready     = cmd_en && !sel_id && sram_cmd_ready;
  assign s1_cmd_ready     = cmd_en &&  sel_id && sram_cmd_ready;
  assign accept           = sram_cmd_valid && sram_cmd_ready;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    hold_d    = hold_q;
    hold_id_d = hold_id_q;
    prio_d    = prio_q;
    if (accept) begin
      hold_d = 1'b0;
      if (c_last[sel_id]) begin
        lock_d = 1'b0;
        prio_d = ~sel_id;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = sel_id;
      end
    end else if (sram_cmd_valid) begin
      hold_d    = 1'b1;
      hold_id_d = sel_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      hold_q    <= 1'b0;
      hold_id_q <= 1'b0;
      prio_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      prio_q    <= prio_d;
    end
  end

  // Response path: tag MSB picks the destination; payload fans out to both.
  logic rsp_id;
  assign rsp_id             = sram_rd_resp_meta[SRAM_META_WIDTH-1];
  assign s0_rd_resp_valid   = rst_n && sram_rd_resp_valid && !rsp_id;
  assign s1_rd_resp_valid   = rst_n && sram_rd_resp_valid &&  rsp_id;
  assign s0_rd_resp_data    = sram_rd_resp_data;
  assign s1_rd_resp_data    = sram_rd_resp_data;
  assign s0_rd_resp_meta    = sram_rd_resp_meta[CLIENT_META_WIDTH-1:0];
  assign s1_rd_resp_meta    = sram_rd_resp_meta[CLIENT_META_WIDTH-1:0];
  assign s0_rd_resp_last    = sram_rd_resp_last;
  assign s1_rd_resp_last    = sram_rd_resp_last;
  assign sram_rd_resp_ready = rst_n && (rsp_id ? s1_rd_resp_ready : s0_rd_resp_ready);

endmodule

// File: tb/tb_svc_sram_arb.sv
// Directed bench for svc_sram_arb: cycle-by-cycle command vectors plus
// hand-written response routing and mid-burst reset sequences.
module tb_svc_sram_arb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s0_cmd_valid, s0_cmd_ready, s0_cmd_last, s0_cmd_wr_en;
  logic [7:0]  s0_cmd_addr;
  logic [3:0]  s0_cmd_meta;
  logic [15:0] s0_cmd_wr_data;
  logic [1:0]  s0_cmd_wr_strb;
  logic        s0_rd_resp_valid, s0_rd_resp_ready, s0_rd_resp_last;
  logic [15:0] s0_rd_resp_data;
  logic [3:0]  s0_rd_resp_meta;
  logic        s1_cmd_valid, s1_cmd_ready, s1_cmd_last, s1_cmd_wr_en;
  logic [7:0]  s1_cmd_addr;
  logic [3:0]  s1_cmd_meta;
  logic [15:0] s1_cmd_wr_data;
  logic [1:0]  s1_cmd_wr_strb;
  logic        s1_rd_resp_valid, s1_rd_resp_ready, s1_rd_resp_last;
  logic [15:0] s1_rd_resp_data;
  logic [3:0]  s1_rd_resp_meta;
  logic        sram_cmd_valid, sram_cmd_ready, sram_cmd_last, sram_cmd_wr_en;
  logic [7:0]  sram_cmd_addr;
  logic [4:0]  sram_cmd_meta;
  logic [15:0] sram_cmd_wr_data;
  logic [1:0]  sram_cmd_wr_strb;
  logic        sram_rd_resp_valid, sram_rd_resp_ready, sram_rd_resp_last;
  logic [15:0] sram_rd_resp_data;
  logic [4:0]  sram_rd_resp_meta;

  svc_sram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready), .s0_cmd_addr(s0_cmd_addr),
    .s0_cmd_meta(s0_cmd_meta), .s0_cmd_last(s0_cmd_last), .s0_cmd_wr_en(s0_cmd_wr_en),
    .s0_cmd_wr_data(s0_cmd_wr_data), .s0_cmd_wr_strb(s0_cmd_wr_strb),
    .s0_rd_resp_valid(s0_rd_resp_valid), .s0_rd_resp_ready(s0_rd_resp_ready),
    .s0_rd_resp_data(s0_rd_resp_data), .s0_rd_resp_meta(s0_rd_resp_meta),
    .s0_rd_resp_last(s0_rd_resp_last),
    .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready), .s1_cmd_addr(s1_cmd_addr),
    .s1_cmd_meta(s1_cmd_meta), .s1_cmd_last(s1_cmd_last), .s1_cmd_wr_en(s1_cmd_wr_en),
    .s1_cmd_wr_data(s1_cmd_wr_data), .s1_cmd_wr_strb(s1_cmd_wr_strb),
    .s1_rd_resp_valid(s1_rd_resp_valid), .s1_rd_resp_ready(s1_rd_resp_ready),
    .s1_rd_resp_data(s1_rd_resp_data), .s1_rd_resp_meta(s1_rd_resp_meta),
    .s1_rd_resp_last(s1_rd_resp_last),
    .sram_cmd_valid(sram_cmd_valid), .sram_cmd_ready(sram_cmd_ready),
    .sram_cmd_addr(sram_cmd_addr), .sram_cmd_meta(sram_cmd_meta),
    .sram_cmd_last(sram_cmd_last), .sram_cmd_wr_en(sram_cmd_wr_en),
    .sram_cmd_wr_data(sram_cmd_wr_data), .sram_cmd_wr_strb(sram_cmd_wr_strb),
    .sram_rd_resp_valid(sram_rd_resp_valid), .sram_rd_resp_ready(sram_rd_resp_ready),
    .sram_rd_resp_data(sram_rd_resp_data), .sram_rd_resp_meta(sram_rd_resp_meta),
    .sram_rd_resp_last(sram_rd_resp_last)
  );

  typedef struct {
    logic       v0, l0;
    logic [7:0] a0;
    logic       v1, l1;
    logic [7:0] a1;
    logic       rdy;
    logic       ev;
    logic [7:0] ea;
    logic [4:0] em;
    logic       er0, er1;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic v0, l0, input logic [7:0] a0,
                              input logic v1, l1, input logic [7:0] a1,
                              input logic rdy, ev, input logic [7:0] ea,
                              input logic [4:0] em, input logic er0, er1);
    vec_t v;
    v.v0 = v0; v.l0 = l0; v.a0 = a0; v.v1 = v1; v.l1 = l1; v.a1 = a1;
    v.rdy = rdy; v.ev = ev; v.ea = ea; v.em = em; v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of command inputs, check mid-cycle, then advance past the edge.
  // s0 issues reads with data 0x1111, s1 issues writes with data 0x2222.
  task automatic apply(input vec_t v, input string nm);
    logic [63:0] act, exp;
    logic        el;
    s0_cmd_valid = v.v0; s0_cmd_last = v.l0; s0_cmd_addr = v.a0;
    s1_cmd_valid = v.v1; s1_cmd_last = v.l1; s1_cmd_addr = v.a1;
    sram_cmd_ready = v.rdy;
    @(negedge clk);
    el  = v.em[4] ? v.l1 : v.l0;
    exp = {38'd0, v.ev, v.er0, v.er1, 23'd0};
    act = {38'd0, sram_cmd_valid, s0_cmd_ready, s1_cmd_ready, 23'd0};
    if (v.ev) begin
      exp[22:0] = {v.ea, v.em, v.em[4], el, (v.em[4] ? 8'h22 : 8'h11)};
      act[22:0] = {sram_cmd_addr, sram_cmd_meta, sram_cmd_wr_en, sram_cmd_last,
                   sram_cmd_wr_data[7:0]};
    end
    chk(nm, act, exp);
    @(posedge clk); #1;
  endtask

  task automatic rsp(input logic v, input logic [4:0] m, input logic [15:0] d,
                     input logic l, input logic r0, input logic r1,
                     input logic ev0, input logic ev1, input logic err, input string nm);
    sram_rd_resp_valid = v; sram_rd_resp_meta = m; sram_rd_resp_data = d;
    sram_rd_resp_last = l; s0_rd_resp_ready = r0; s1_rd_resp_ready = r1;
    @(negedge clk);
    chk(nm, {s0_rd_resp_valid, s1_rd_resp_valid, sram_rd_resp_ready,
             s0_rd_resp_data, s1_rd_resp_data, s0_rd_resp_meta, s1_rd_resp_meta,
             s0_rd_resp_last, s1_rd_resp_last},
            {ev0, ev1, err, d, d, m[3:0], m[3:0], l, l});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s0_cmd_valid = 1'b1; s0_cmd_last = 1'b1; s0_cmd_addr = 8'h00; s0_cmd_meta = 4'h3;
    s0_cmd_wr_en = 1'b0; s0_cmd_wr_data = 16'h1111; s0_cmd_wr_strb = 2'b11;
    s1_cmd_valid = 1'b1; s1_cmd_last = 1'b1; s1_cmd_addr = 8'h00; s1_cmd_meta = 4'h5;
    s1_cmd_wr_en = 1'b1; s1_cmd_wr_data = 16'h2222; s1_cmd_wr_strb = 2'b01;
    sram_cmd_ready = 1'b1;
    sram_rd_resp_valid = 1'b1; sram_rd_resp_meta = 5'h03; sram_rd_resp_data = 16'h0;
    sram_rd_resp_last = 1'b0; s0_rd_resp_ready = 1'b1; s1_rd_resp_ready = 1'b1;

    // Vector table: rows are consecutive cycles; arbiter state carries across rows.
    vecs.push_back(mk(1,1,8'h10, 0,0,8'h00, 1, 1,8'h10,5'h03, 1,0)); // single s0 read
    vecs.push_back(mk(0,0,8'h00, 1,1,8'h11, 1, 1,8'h11,5'h15, 0,1)); // s1 alone, prio->0
    for (int i = 0; i < 8; i++)                                      // alternation
      vecs.push_back((i % 2 == 0) ? mk(1,1,8'h30, 1,1,8'h40, 1, 1,8'h30,5'h03, 1,0)
                                  : mk(1,1,8'h30, 1,1,8'h40, 1, 1,8'h40,5'h15, 0,1));
    vecs.push_back(mk(1,1,8'h50, 0,0,8'h00, 1, 1,8'h50,5'h03, 1,0)); // prio->1
    vecs.push_back(mk(1,1,8'h50, 1,0,8'h20, 1, 1,8'h20,5'h15, 0,1)); // s1 burst beat 1
    vecs.push_back(mk(1,1,8'h50, 1,0,8'h21, 1, 1,8'h21,5'h15, 0,1));
    vecs.push_back(mk(1,1,8'h50, 0,0,8'h22, 1, 0,8'h00,5'h00, 0,1)); // s1 gap, still locked
    vecs.push_back(mk(1,1,8'h50, 1,0,8'h22, 1, 1,8'h22,5'h15, 0,1));
    vecs.push_back(mk(1,1,8'h50, 1,1,8'h23, 1, 1,8'h23,5'h15, 0,1)); // last beat
    vecs.push_back(mk(1,1,8'h50, 0,0,8'h00, 1, 1,8'h50,5'h03, 1,0)); // s0 after burst
    for (int i = 0; i < 3; i++)                                      // s0 stalled
      vecs.push_back(mk(1,1,8'h60, 0,0,8'h00, 0, 1,8'h60,5'h03, 0,0));
    vecs.push_back(mk(1,1,8'h60, 1,1,8'h70, 0, 1,8'h60,5'h03, 0,0)); // s1 prio, hold s0
    vecs.push_back(mk(1,1,8'h60, 1,1,8'h70, 1, 1,8'h60,5'h03, 1,0)); // accepted
    vecs.push_back(mk(1,1,8'h61, 1,1,8'h70, 1, 1,8'h70,5'h15, 0,1));

    // Reset state with everything requesting.
    @(negedge clk);
    chk("reset_outputs", {sram_cmd_valid, s0_cmd_ready, s1_cmd_ready,
                          s0_rd_resp_valid, s1_rd_resp_valid}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sram_rd_resp_valid = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Response routing and backpressure.
    rsp(1, 5'h03, 16'hBEEF, 1, 1, 1, 1, 0, 1, "rsp_s0");
    rsp(1, 5'h1A, 16'hCAFE, 0, 1, 0, 0, 1, 0, "rsp_s1_stall1");
    rsp(1, 5'h1A, 16'hCAFE, 0, 1, 0, 0, 1, 0, "rsp_s1_stall2");
    rsp(1, 5'h1A, 16'hCAFE, 0, 1, 1, 0, 1, 1, "rsp_s1_accept");
    rsp(0, 5'h1A, 16'hCAFE, 0, 1, 1, 0, 0, 1, "rsp_idle");

    // Reset in the middle of an s1 burst, with priority pointing at s1.
    apply(mk(1,1,8'h50, 0,0,8'h00, 1, 1,8'h50,5'h03, 1,0), "rst_pre_s0");
    apply(mk(0,0,8'h00, 1,0,8'h90, 1, 1,8'h90,5'h15, 0,1), "rst_burst_b1");
    apply(mk(0,0,8'h00, 1,0,8'h91, 1, 1,8'h91,5'h15, 0,1), "rst_burst_b2");
    rst_n = 1'b0;
    sram_rd_resp_valid = 1'b1; sram_rd_resp_meta = 5'h10;
    s0_cmd_valid = 1'b1; s1_cmd_valid = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {sram_cmd_valid, s0_cmd_ready, s1_cmd_ready,
                           s0_rd_resp_valid, s1_rd_resp_valid}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sram_rd_resp_valid = 1'b0;
    apply(mk(1,1,8'h80, 1,1,8'h92, 1, 1,8'h80,5'h03, 1,0), "post_rst_s0");
    apply(mk(1,1,8'h81, 1,1,8'h92, 1, 1,8'h92,5'h15, 0,1), "post_rst_s1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
